// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count derivation, core FSM states, GF(2^8)
// arithmetic, the inverse S-box and byte addressing of the column-major state.
// Byte order: bit 0 of a 128-bit block is the MSB of byte 0; byte index = 4*col + row.
package aes_pkg;

  // Round count for a key of nk 32-bit words (4/6/8 -> 10/12/14).
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } fsm_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry b lives at bits (255-b)*8 +: 8, and (255-b)*8 == {~b, 3'b000}.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  // Byte index of (row, col) in the column-major state.
  function automatic int bidx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/inv_round_comb.sv
// One AES inverse round, purely combinational:
//   InvShiftRows -> InvSubBytes -> AddRoundKey(rk) -> InvMixColumns (skipped when is_final).
// Ports: state/rk in (128b, byte 0 first), is_final selects the last-round form, next_state out.
module inv_round_comb
  import aes_pkg::*;
(
  input  logic [0:127] state,
  input  logic [0:127] rk,
  input  logic         is_final,
  output logic [0:127] next_state
);

  logic [0:127] sub_shift;
  logic [0:127] ark;
  logic [0:127] mix;

  // One output byte of InvMixColumns; rows use the same coefficients rotated.
  function automatic logic [7:0] inv_mix(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    return gf_mul(a, 8'h0e) ^ gf_mul(b, 8'h0b) ^ gf_mul(c, 8'h0d) ^ gf_mul(d, 8'h09);
  endfunction

  always_comb begin
    sub_shift = '0;
    mix       = '0;
    // Row r rotates right by r: output column c takes input column c-r.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sub_shift[8*bidx(r, c) +: 8] = inv_sbox(state[8*bidx(r, (c - r + 4) % 4) +: 8]);
      end
    end
    ark = sub_shift ^ rk;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mix[8*bidx(r, c) +: 8] = inv_mix(ark[8*bidx(r, c) +: 8],
                                         ark[8*bidx((r + 1) % 4, c) +: 8],
                                         ark[8*bidx((r + 2) % 4, c) +: 8],
                                         ark[8*bidx((r + 3) % 4, c) +: 8]);
      end
    end
    next_state = is_final ? ark : mix;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption core: one inverse round per clock, round keys fetched by index.
// Latency: out_valid rises Nr edges after the input handshake; one block per Nr+2 cycles.
// Backpressure: holds the plaintext in DONE until out_ready; accepts nothing outside IDLE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_block ciphertext handshake;
//        rk_idx/rk combinational key-store lookup; out_valid/out_ready/out_block plaintext.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_of(Nk)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [0:127]               in_block,
  output logic [$clog2(Nr+1)-1:0]    rk_idx,
  input  logic [0:127]               rk,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [0:127]               out_block
);

  localparam int            IW   = $clog2(Nr + 1);
  localparam logic [IW-1:0] NR_L = IW'(Nr);
  localparam logic [IW-1:0] ONE  = IW'(1);

  fsm_t          fsm_q, fsm_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [0:127]  blk_q, blk_d;
  logic [0:127]  round_out;

  inv_round_comb u_round (
    .state      (blk_q),
    .rk         (rk),
    .is_final   (fsm_q == ST_FINAL),
    .next_state (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
      cnt_q <= NR_L;
      blk_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = '0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = NR_L;
        if (in_valid) begin
          blk_d = in_block ^ rk;  // initial AddRoundKey with the last round key
          cnt_d = NR_L - ONE;
          fsm_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx = cnt_q;
        blk_d  = round_out;
        if (cnt_q == ONE) fsm_d = ST_FINAL;
        else              cnt_d = cnt_q - ONE;
      end
      ST_FINAL: begin
        rk_idx = '0;
        blk_d  = round_out;
        fsm_d  = ST_DONE;
      end
      ST_DONE: begin
        // Key store is not needed here; rk_idx stays 0.
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = ST_IDLE;
          cnt_d = NR_L;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign out_block = blk_q;

endmodule
